l2_bus_interface: RTL and testbench

L2_BUS_INTERFACE -- requirements
Module: l2_bus_interface

---
 rtl/l2_bus_interface.sv | 161 ++++++++++++++++
 tb/tb_l2_bus_interface.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_bus_interface.sv
// L2 bus interface: request FIFO feeding an address/snoop/data/response
// sequencer for line-sized bus transactions.
module l2_bus_interface #(
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 4,
  parameter int OFFSET_W   = 6,
  parameter int SNOOP_WAIT = 2,
  parameter int LINE_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              bus_valid,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic [1:0]        snoop_in,
  input  logic              bus_beat,
  output logic              rsp_valid,
  output logic [1:0]        rsp_op,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [1:0]        rsp_snoop,
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_SNOOP = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] OP_INV = 2'b10;

  logic [1:0]        r_q_op   [DEPTH];
  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_nonempty;

  logic [2:0]        r_state;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_snoop;
  logic [3:0]        r_wait;
  logic [3:0]        r_beat;

  logic w_ready;
  logic w_push;
  logic w_pop;

  assign w_ready = (r_count != FULL_CNT);
  assign w_push  = req_valid && w_ready;
  // r_nonempty lags the count by one edge so a fresh push waits a cycle
  assign w_pop   = (r_state == S_IDLE) && r_nonempty &&
                   (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_nonempty <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_op[i]   <= '0;
        r_q_addr[i] <= '0;
      end
    end else begin
      r_nonempty <= (r_count != '0);
      if (w_push) begin
        r_q_op[r_wr_ptr]   <= req_op;
        r_q_addr[r_wr_ptr] <= req_addr & LINE_MASK;
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_addr  <= '0;
      r_snoop <= '0;
      r_wait  <= '0;
      r_beat  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_op    <= r_q_op[r_rd_ptr];
            r_addr  <= r_q_addr[r_rd_ptr];
            r_snoop <= '0;
            r_beat  <= '0;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus_ack) begin
            r_wait  <= 4'(SNOOP_WAIT - 1);
            r_state <= S_SNOOP;
          end
        end
        S_SNOOP: begin
          if (r_wait == '0) begin
            r_snoop <= (snoop_in == 2'b11) ? 2'b00 : snoop_in;
            r_beat  <= '0;
            r_state <= (r_op == OP_INV) ? S_RESP : S_DATA;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_DATA: begin
          if (bus_beat) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == 4'(LINE_BEATS - 1)) begin
              r_state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    req_ready = w_ready;
    bus_valid = (r_state == S_ADDR);
    bus_op    = bus_valid ? r_op : 2'b00;
    bus_addr  = bus_valid ? r_addr : '0;
    rsp_valid = (r_state == S_RESP);
    rsp_op    = rsp_valid ? r_op : 2'b00;
    rsp_addr  = rsp_valid ? r_addr : '0;
    rsp_snoop = rsp_valid ? r_snoop : 2'b00;
    busy      = (r_state != S_IDLE) || (r_count != '0);
  end

endmodule

// File: tb/tb_l2_bus_interface.sv
// Self-checking bench for l2_bus_interface: directed protocol scenarios
// plus randomized transactions against a transaction-level expectation.
module tb_l2_bus_interface;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int SW    = 2;
  localparam int LB    = 4;

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_INV  = 2'b10;
  localparam logic [1:0] OP_RWIM = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [AW-1:0] req_addr = '0;
  logic          bus_valid;
  logic [1:0]    bus_op;
  logic [AW-1:0] bus_addr;
  logic          bus_ack = 1'b0;
  logic [1:0]    snoop_in = '0;
  logic          bus_beat = 1'b0;
  logic          rsp_valid;
  logic [1:0]    rsp_op;
  logic [AW-1:0] rsp_addr;
  logic [1:0]    rsp_snoop;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  l2_bus_interface #(
    .ADDR_W(AW), .DEPTH(DEPTH), .OFFSET_W(6),
    .SNOOP_WAIT(SW), .LINE_BEATS(LB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_ack(bus_ack), .snoop_in(snoop_in), .bus_beat(bus_beat),
    .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_addr(rsp_addr),
    .rsp_snoop(rsp_snoop), .busy(busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push(input logic [1:0] op, input logic [31:0] addr);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL push_ready: req_ready=%b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
  endtask

  task automatic serve(input logic [1:0] op, input logic [31:0] addr,
                       input logic [1:0] snp, input int ack_dly,
                       input bit snoop_beats, input bit dense,
                       input int abort_at, output bit ok);
    logic [31:0] ea;
    logic [1:0]  es;
    int n;
    int g;
    bit b;
    ea = addr & ~32'h3F;
    es = (snp == 2'b11) ? 2'b00 : snp;
    ok = 1'b0;
    g = 0;
    while (bus_valid !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (bus_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_timeout: bus_valid=%b want 1", bus_valid);
      return;
    end
    n_checks++;
    if (bus_op !== op || bus_addr !== ea) begin
      n_fail++;
      $display("FAIL addr_phase: op=%b addr=%h want op=%b addr=%h",
               bus_op, bus_addr, op, ea);
    end
    for (int i = 0; i < ack_dly; i++) begin
      bus_ack  = 1'b0;
      bus_beat = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (bus_valid !== 1'b1 || bus_op !== op || bus_addr !== ea) begin
        n_fail++;
        $display("FAIL addr_hold: valid=%b op=%b addr=%h want 1 %b %h",
                 bus_valid, bus_op, bus_addr, op, ea);
      end
    end
    bus_ack  = 1'b1;
    bus_beat = 1'b0;
    @(negedge clk);
    bus_ack = 1'b0;
    n_checks++;
    if (bus_valid !== 1'b0 || bus_op !== 2'b00 || bus_addr !== '0) begin
      n_fail++;
      $display("FAIL addr_release: valid=%b op=%b addr=%h want 0 0 0",
               bus_valid, bus_op, bus_addr);
    end
    for (int k = 1; k <= SW; k++) begin
      snoop_in = (k == SW) ? snp : 2'($urandom);
      bus_beat = snoop_beats ? 1'b1 : 1'($urandom);
      bus_ack  = 1'($urandom);
      @(negedge clk);
      if (k < SW) begin
        n_checks++;
        if (rsp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL snoop_rsp: rsp_valid=%b want 0", rsp_valid);
        end
      end
    end
    bus_ack  = 1'b0;
    snoop_in = 2'($urandom);
    if (op != OP_INV) begin
      n = 0;
      g = 0;
      while (n < LB) begin
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_op !== 2'b00 ||
            rsp_addr !== '0 || rsp_snoop !== 2'b00) begin
          n_fail++;
          $display("FAIL rsp_early: valid=%b addr=%h beats=%0d want 0",
                   rsp_valid, rsp_addr, n);
        end
        if (abort_at >= 0 && n == abort_at) begin
          bus_beat = 1'b0;
          ok = 1'b1;
          return;
        end
        b = dense ? 1'b1 : 1'($urandom);
        bus_beat = b;
        if (b) n++;
        @(negedge clk);
        g++;
        if (g > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_timeout: beats=%0d want %0d", n, LB);
          bus_beat = 1'b0;
          return;
        end
      end
      bus_beat = 1'b0;
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_op !== op || rsp_addr !== ea ||
        rsp_snoop !== es) begin
      n_fail++;
      $display("FAIL rsp: valid=%b op=%b addr=%h snp=%b want 1 %b %h %b",
               rsp_valid, rsp_op, rsp_addr, rsp_snoop, op, ea, es);
    end
    @(negedge clk);
    bus_beat = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_addr !== '0) begin
      n_fail++;
      $display("FAIL rsp_one_cycle: valid=%b addr=%h want 0 0",
               rsp_valid, rsp_addr);
    end
    ok = 1'b1;
  endtask

  task automatic do_txn(input logic [1:0] op, input logic [31:0] addr,
                        input logic [1:0] snp, input int ack_dly,
                        input bit snoop_beats, input bit dense);
    bit ok;
    push(op, addr);
    n_checks++;
    if (bus_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_latency1: bus_valid=%b want 0", bus_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_latency2: bus_valid=%b want 0", bus_valid);
    end
    serve(op, addr, snp, ack_dly, snoop_beats, dense, -1, ok);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || bus_valid !== 1'b0 || rsp_valid !== 1'b0 ||
        busy !== 1'b0 || bus_addr !== '0 || rsp_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b bv=%b rv=%b busy=%b want 1 0 0 0",
               req_ready, bus_valid, rsp_valid, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || bus_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b busy=%b bv=%b want 1 0 0",
               req_ready, busy, bus_valid);
    end
  endtask

  task automatic test_read_basic();
    do_txn(OP_RD, 32'h0000_1234, 2'b01, 1, 1'b0, 1'b1);
  endtask

  task automatic test_invalidate();
    do_txn(OP_INV, 32'h0000_0040, 2'b00, 1, 1'b1, 1'b1);
  endtask

  task automatic test_rwim_reserved_snoop();
    do_txn(OP_RWIM, $urandom, 2'b11, 0, 1'b1, 1'b0);
  endtask

  task automatic test_fifo_full();
    logic [31:0] qa[$];
    logic [1:0]  qo[$];
    logic [31:0] a;
    logic [1:0]  o;
    bit exp_rdy;
    bit ok;
    bus_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      o = 2'($urandom);
      exp_rdy = (qa.size() < DEPTH + 1);
      req_valid = 1'b1;
      req_op    = o;
      req_addr  = a;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL full_ready[%0d]: req_ready=%b want %b",
                 i, req_ready, exp_rdy);
      end
      if (exp_rdy) begin
        qa.push_back(a);
        qo.push_back(o);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_hold: req_ready=%b busy=%b want 0 1",
               req_ready, busy);
    end
    while (qa.size() > 0) begin
      serve(qo[0], qa[0], 2'($urandom), $urandom_range(0, 2),
            1'b0, 1'b0, -1, ok);
      void'(qa.pop_front());
      void'(qo.pop_front());
    end
    n_checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drain: busy=%b req_ready=%b want 0 1",
               busy, req_ready);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] a;
    bit ok;
    a = $urandom;
    push(OP_WR, a);
    serve(OP_WR, a, 2'b01, 0, 1'b0, 1'b1, 2, ok);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || bus_valid !== 1'b0 || bus_addr !== '0 ||
        rsp_valid !== 1'b0 || rsp_addr !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_reset: rdy=%b bv=%b rv=%b busy=%b want 1 0 0 0",
               req_ready, bus_valid, rsp_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_beat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL dropped_write: rsp_valid=%b busy=%b want 0 0",
                 rsp_valid, busy);
      end
    end
    bus_beat = 1'b0;
    do_txn(OP_RD, $urandom, 2'b10, 1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] qa[3];
    logic [1:0]  qo[3];
    bit ok;
    for (int i = 0; i < 3; i++) begin
      qa[i] = $urandom;
      qo[i] = 2'($urandom);
      push(qo[i], qa[i]);
    end
    for (int i = 0; i < 3; i++) begin
      serve(qo[i], qa[i], 2'($urandom), 0, 1'b0, 1'b1, -1, ok);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      do_txn(2'($urandom), $urandom, 2'($urandom), $urandom_range(0, 3),
             1'($urandom), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_invalidate();
    test_rwim_reserved_snoop();
    test_fifo_full();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
